// File: rtl/instr_byte_loader_pkg.sv
// ---------------------------------------------------------------------------
// instr_byte_loader_pkg
// Shared types and constants for the instruction byte loader.
//   loaderState_t  : session state machine encoding (IDLE/LOAD/WRITE/DONE)
//   BYTES_PER_WORD : bytes assembled into one instruction word
//   IDX_W          : width of the byte-within-word index
// ---------------------------------------------------------------------------
package instr_byte_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loaderState_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = 2;

endpackage

// File: rtl/instr_byte_loader_sync.sv
// ---------------------------------------------------------------------------
// sync_ff
// Single-bit multi-flop synchronizer for a pin that is asynchronous to clk.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (chain clears to 0)
//   i_d   : asynchronous input level
//   o_q   : synchronized level, STAGES clock edges behind i_d
// ---------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift chain; only the first flop may go metastable, later ones settle it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/instr_byte_loader.sv
// ---------------------------------------------------------------------------
// instr_byte_loader
// Assembles little-endian 32-bit instruction words from bytes delivered over
// a 4-phase strobe/ack pin handshake and writes them into instruction RAM.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   load_en      : async pin, high while a load session is active
//   byte_strobe  : async pin, rising edge marks byte_in valid
//   byte_in      : data byte, stable from strobe rise until byte_ack rises
//   byte_ack     : handshake acknowledge back to the tester
//   mem_we       : one-cycle RAM write pulse per completed word
//   mem_addr     : word address of the write
//   mem_wdata    : assembled word
//   cpu_run      : core released (only in DONE)
//   word_count   : words written this session, saturates at 2^ADDR_W
//   err_partial  : sticky, session ended with 1-3 unwritten bytes
//   err_overflow : sticky, a word completed after memory was full
// ---------------------------------------------------------------------------
import instr_byte_loader_pkg::*;

module instr_byte_loader #(
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              byte_strobe,
    input  logic [7:0]        byte_in,
    output logic              byte_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic [ADDR_W:0]   word_count,
    output logic              err_partial,
    output logic              err_overflow
);

    loaderState_t       r_state;
    loaderState_t       w_nextState;

    logic               w_loadSync;
    logic               w_strobeSync;
    logic               r_loadPrev;
    logic               r_strobePrev;
    logic               r_ackSet;
    logic               r_byteAck;

    logic [IDX_W-1:0]   r_byteIdx;
    logic [23:0]        r_asm;
    logic [ADDR_W-1:0]  r_ptr;
    logic [ADDR_W:0]    r_wordCount;
    logic [ADDR_W-1:0]  r_memAddr;
    logic [31:0]        r_memWdata;
    logic               r_errPartial;
    logic               r_errOverflow;

    logic               w_loadRise;
    logic               w_strobeRise;
    logic               w_capture;
    logic               w_lastByte;
    logic               w_full;
    logic               w_startSession;
    logic               w_memWe;
    logic               w_cpuRun;

    sync_ff #(.STAGES(SYNC_STAGES)) u_syncLoad (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (load_en),
        .o_q   (w_loadSync)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_syncStrobe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (byte_strobe),
        .o_q   (w_strobeSync)
    );

    assign w_loadRise     = w_loadSync & ~r_loadPrev;
    assign w_strobeRise   = w_strobeSync & ~r_strobePrev;
    assign w_full         = r_wordCount[ADDR_W];
    assign w_lastByte     = (r_byteIdx == IDX_W'(BYTES_PER_WORD - 1));
    // A strobe in WRITE is byte 0 of the next word; the assembly register is
    // separate from mem_wdata so it can be captured while the write happens.
    assign w_capture      = w_strobeRise & w_loadSync &
                            ((r_state == LOAD) || (r_state == WRITE));
    assign w_startSession = w_loadRise & ((r_state == IDLE) || (r_state == DONE));

    // Edge-detect history and the ack handshake; ack is acknowledged for every
    // strobe regardless of state so the tester can never stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loadPrev   <= 1'b0;
            r_strobePrev <= 1'b0;
            r_ackSet     <= 1'b0;
            r_byteAck    <= 1'b0;
        end else begin
            r_loadPrev   <= w_loadSync;
            r_strobePrev <= w_strobeSync;
            r_ackSet     <= w_strobeRise;
            if (r_ackSet) begin
                r_byteAck <= 1'b1;
            end else if (!w_strobeSync) begin
                r_byteAck <= 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A completed word with memory full stays in LOAD.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_loadRise) w_nextState = LOAD;
            end
            LOAD: begin
                if (!w_loadSync) begin
                    w_nextState = DONE;
                end else if (w_capture && w_lastByte && !w_full) begin
                    w_nextState = WRITE;
                end
            end
            WRITE: begin
                w_nextState = w_loadSync ? LOAD : DONE;
            end
            DONE: begin
                if (w_loadRise) w_nextState = LOAD;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Moore outputs.
    always_comb begin
        w_memWe  = 1'b0;
        w_cpuRun = 1'b0;
        case (r_state)
            WRITE:   w_memWe  = 1'b1;
            DONE:    w_cpuRun = 1'b1;
            default: ;
        endcase
    end

    // Datapath: byte assembly, word hand-off, pointer/count and sticky errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byteIdx     <= '0;
            r_asm         <= '0;
            r_ptr         <= '0;
            r_wordCount   <= '0;
            r_memAddr     <= '0;
            r_memWdata    <= '0;
            r_errPartial  <= 1'b0;
            r_errOverflow <= 1'b0;
        end else if (w_startSession) begin
            r_byteIdx     <= '0;
            r_ptr         <= '0;
            r_wordCount   <= '0;
            r_errPartial  <= 1'b0;
            r_errOverflow <= 1'b0;
        end else begin
            if (r_state == WRITE) begin
                r_ptr       <= r_ptr + ADDR_W'(1);
                r_wordCount <= r_wordCount + (ADDR_W + 1)'(1);
            end

            if (r_state == LOAD && !w_loadSync) begin
                // Session ended; any bytes of an unfinished word are dropped.
                if (r_byteIdx != '0) r_errPartial <= 1'b1;
                r_byteIdx <= '0;
            end else if (w_capture) begin
                if (w_lastByte) begin
                    r_byteIdx <= '0;
                    if (w_full) begin
                        r_errOverflow <= 1'b1;
                    end else begin
                        r_memAddr  <= r_ptr;
                        r_memWdata <= {byte_in, r_asm};
                    end
                end else begin
                    r_byteIdx <= r_byteIdx + IDX_W'(1);
                    case (r_byteIdx)
                        2'd0:    r_asm[7:0]   <= byte_in;
                        2'd1:    r_asm[15:8]  <= byte_in;
                        default: r_asm[23:16] <= byte_in;
                    endcase
                end
            end
        end
    end

    assign byte_ack     = r_byteAck;
    assign mem_we       = w_memWe;
    assign mem_addr     = r_memAddr;
    assign mem_wdata    = r_memWdata;
    assign cpu_run      = w_cpuRun;
    assign word_count   = r_wordCount;
    assign err_partial  = r_errPartial;
    assign err_overflow = r_errOverflow;

endmodule

// File: tb/tb_instr_byte_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_byte_loader
// Directed testbench for instr_byte_loader, built with a 4-word memory so the
// full-memory behaviour is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_instr_byte_loader;

    localparam int ADDR_W      = 2;
    localparam int SYNC_STAGES = 2;

    logic              clk;
    logic              rst_n;
    logic              load_en;
    logic              byte_strobe;
    logic [7:0]        byte_in;
    logic              byte_ack;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_run;
    logic [ADDR_W:0]   word_count;
    logic              err_partial;
    logic              err_overflow;

    int compareCount  = 0;
    int mismatchCount = 0;

    int          writeCount = 0;
    int          wrAddr [16];
    logic [31:0] wrData [16];

    int          lat;
    logic [31:0] ovfWords [5];

    instr_byte_loader #(
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_en      (load_en),
        .byte_strobe  (byte_strobe),
        .byte_in      (byte_in),
        .byte_ack     (byte_ack),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_run      (cpu_run),
        .word_count   (word_count),
        .err_partial  (err_partial),
        .err_overflow (err_overflow)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Logs every RAM write; mem_we spans a whole cycle so the falling edge
    // sees each pulse exactly once.
    always @(negedge clk) begin
        if (mem_we) begin
            if (writeCount < 16) begin
                wrAddr[writeCount] = int'(mem_addr);
                wrData[writeCount] = mem_wdata;
            end
            writeCount = writeCount + 1;
        end
    end

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount = compareCount + 1;
        if (observed !== expected) begin
            mismatchCount = mismatchCount + 1;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Full 4-phase handshake for one byte; returns posedges from strobe rise
    // until byte_ack was seen high.
    task automatic applyStimulus(input logic [7:0] b, output int ackLat);
        int cnt;
        @(negedge clk);
        byte_in     = b;
        byte_strobe = 1'b1;
        ackLat      = 0;
        while (!byte_ack && ackLat < 40) begin
            @(posedge clk);
            #1;
            ackLat = ackLat + 1;
        end
        checkOutput("ackRise", 32'(byte_ack), 32'd1);
        @(negedge clk);
        byte_strobe = 1'b0;
        cnt = 0;
        while (byte_ack && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt = cnt + 1;
        end
        checkOutput("ackFall", 32'(byte_ack), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Sends a word as four little-endian bytes.
    task automatic sendWord(input logic [31:0] w);
        int l;
        applyStimulus(w[7:0], l);
        applyStimulus(w[15:8], l);
        applyStimulus(w[23:16], l);
        applyStimulus(w[31:24], l);
    endtask

    task automatic startSession();
        @(negedge clk);
        load_en = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic endSession();
        @(negedge clk);
        load_en = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        load_en     = 1'b0;
        byte_strobe = 1'b0;
        byte_in     = 8'h00;

        // Reset held while pins toggle: everything stays at zero.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            load_en     = ~load_en;
            byte_strobe = ~byte_strobe;
            byte_in     = 8'(i * 37);
        end
        @(negedge clk);
        checkOutput("rstAck",      32'(byte_ack),     32'd0);
        checkOutput("rstCpuRun",   32'(cpu_run),      32'd0);
        checkOutput("rstWordCnt",  32'(word_count),   32'd0);
        checkOutput("rstErrs",     32'({err_partial, err_overflow}), 32'd0);
        checkOutput("rstMemWdata", mem_wdata,         32'd0);
        checkOutput("rstWrites",   32'(writeCount),   32'd0);
        load_en     = 1'b0;
        byte_strobe = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("idleCpuRun", 32'(cpu_run),    32'd0);
        checkOutput("idleWrites", 32'(writeCount), 32'd0);

        // Normal two-word load.
        startSession();
        applyStimulus(8'h78, lat);
        checkOutput("ackLatency", 32'(lat), 32'(SYNC_STAGES + 2));
        applyStimulus(8'h56, lat);
        applyStimulus(8'h34, lat);
        applyStimulus(8'h12, lat);
        sendWord(32'hDEADBEEF);
        endSession();
        checkOutput("normWrites",  32'(writeCount), 32'd2);
        checkOutput("normAddr0",   32'(wrAddr[0]),  32'd0);
        checkOutput("normData0",   wrData[0],       32'h12345678);
        checkOutput("normAddr1",   32'(wrAddr[1]),  32'd1);
        checkOutput("normData1",   wrData[1],       32'hDEADBEEF);
        checkOutput("normWordCnt", 32'(word_count), 32'd2);
        checkOutput("normCpuRun",  32'(cpu_run),    32'd1);
        checkOutput("normErrs",    32'({err_partial, err_overflow}), 32'd0);

        // Partial: one full word plus two stray bytes.
        writeCount = 0;
        startSession();
        checkOutput("partCpuRun0", 32'(cpu_run), 32'd0);
        sendWord(32'hCAFEF00D);
        applyStimulus(8'hAA, lat);
        applyStimulus(8'hBB, lat);
        endSession();
        checkOutput("partWrites",  32'(writeCount), 32'd1);
        checkOutput("partAddr0",   32'(wrAddr[0]),  32'd0);
        checkOutput("partData0",   wrData[0],       32'hCAFEF00D);
        checkOutput("partErr",     32'(err_partial), 32'd1);
        checkOutput("partCpuRun",  32'(cpu_run),    32'd1);
        checkOutput("partWordCnt", 32'(word_count), 32'd1);

        // Reload from DONE: cpu_run drops SYNC_STAGES+1 edges after the pin.
        writeCount = 0;
        @(negedge clk);
        load_en = 1'b1;
        lat = 0;
        while (cpu_run && lat < 40) begin
            @(posedge clk);
            #1;
            lat = lat + 1;
        end
        checkOutput("reloadLatency", 32'(lat), 32'(SYNC_STAGES + 1));
        repeat (4) @(negedge clk);
        checkOutput("reloadErrClr", 32'(err_partial), 32'd0);
        checkOutput("reloadCntClr", 32'(word_count),  32'd0);
        sendWord(32'h0BADC0DE);
        endSession();
        checkOutput("reloadWrites", 32'(writeCount), 32'd1);
        checkOutput("reloadAddr0",  32'(wrAddr[0]),  32'd0);
        checkOutput("reloadData0",  wrData[0],       32'h0BADC0DE);

        // Overflow: five words into a four-word memory.
        ovfWords[0] = 32'h03020100;
        ovfWords[1] = 32'h13121110;
        ovfWords[2] = 32'h23222120;
        ovfWords[3] = 32'h33323130;
        ovfWords[4] = 32'h43424140;
        writeCount = 0;
        startSession();
        for (int w = 0; w < 5; w++) begin
            sendWord(ovfWords[w]);
        end
        endSession();
        checkOutput("ovfWrites", 32'(writeCount), 32'd4);
        for (int w = 0; w < 4; w++) begin
            checkOutput($sformatf("ovfAddr%0d", w), 32'(wrAddr[w]), 32'(w));
            checkOutput($sformatf("ovfData%0d", w), wrData[w], ovfWords[w]);
        end
        checkOutput("ovfWordCnt",  32'(word_count),   32'd4);
        checkOutput("ovfErr",      32'(err_overflow), 32'd1);
        checkOutput("ovfPartial",  32'(err_partial),  32'd0);
        checkOutput("ovfHoldAddr", 32'(mem_addr),     32'd3);
        checkOutput("ovfHoldData", mem_wdata,         32'h33323130);

        // Reset in the middle of a word, then a clean load.
        writeCount = 0;
        startSession();
        applyStimulus(8'h11, lat);
        applyStimulus(8'h22, lat);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checkOutput("midRstAddr", 32'(mem_addr),  32'd0);
        checkOutput("midRstData", mem_wdata,      32'd0);
        checkOutput("midRstErrs", 32'({err_partial, err_overflow}), 32'd0);
        load_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("midRstWrites", 32'(writeCount), 32'd0);
        checkOutput("midRstCpuRun", 32'(cpu_run),    32'd0);
        startSession();
        sendWord(32'h89ABCDEF);
        endSession();
        checkOutput("freshWrites", 32'(writeCount), 32'd1);
        checkOutput("freshAddr0",  32'(wrAddr[0]),  32'd0);
        checkOutput("freshData0",  wrData[0],       32'h89ABCDEF);
        checkOutput("freshCpuRun", 32'(cpu_run),    32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
